display_scheduler: RTL and testbench

- Controller sequencing the 4-digit BCD display driver: generates its `mode[1:0]` and `data_in[15:0]`.
- Shows the ID splash after reset, then the latest temperature reading.
- Grants a set-point source temporary ownership of the display through a req/ack handshake.
- Blinks the temperature while the alarm is active.

---
 rtl/display_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_display_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Display sequencer for the 4-digit BCD driver. It shows the ID splash after reset, then the
// latest temperature. It also runs the set-point req/ack handshake and blinks the reading while the alarm is high.
module display_scheduler #(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned SPLASH_TICKS = 2000,
    parameter int unsigned HOLD_TICKS   = 3000,
    parameter int unsigned BLINK_TICKS  = 250,
    parameter int unsigned MAX_VAL      = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        temp_valid,
    input  logic [15:0] temp_data,
    input  logic        set_req,
    input  logic [15:0] set_data,
    output logic        set_ack,
    input  logic        alarm,
    output logic [1:0]  disp_mode,
    output logic [15:0] disp_data,
    output logic [1:0]  state
);

    localparam logic [1:0] SPLASH = 2'b00;
    localparam logic [1:0] WAIT   = 2'b01;
    localparam logic [1:0] TEMP   = 2'b10;
    localparam logic [1:0] SET    = 2'b11;

    localparam logic [1:0] MODE_ID    = 2'b00;
    localparam logic [1:0] MODE_NUM   = 2'b01;
    localparam logic [1:0] MODE_BLANK = 2'b10;

    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TM1  = (SPLASH_TICKS > HOLD_TICKS) ? SPLASH_TICKS : HOLD_TICKS;
    localparam int unsigned TMAX = (TM1 > BLINK_TICKS) ? TM1 : BLINK_TICKS;
    localparam int unsigned CW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] SPLASH_LAST = CW'(SPLASH_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] BLINK_LAST  = CW'(BLINK_TICKS - 1);
    localparam logic [15:0]   MAX_V       = 16'(MAX_VAL);

    function automatic logic [15:0] sat(input logic [15:0] x);
        return (x > MAX_V) ? MAX_V : x;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    state_q, state_d;
    logic [15:0]   temp_reg_q, temp_reg_d;
    logic [15:0]   set_reg_q, set_reg_d;
    logic          have_temp_q, have_temp_d;
    logic          blink_q, blink_d;
    logic          armed_q, armed_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   data_q, data_d;
    logic          tick, grant;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);

        // armed tracks the mandatory low cycle on set_req between grants
        grant   = set_req && armed_q && (state_q != SPLASH);
        armed_d = grant ? 1'b0 : (!set_req ? 1'b1 : armed_q);

        temp_reg_d  = temp_valid ? sat(temp_data) : temp_reg_q;
        have_temp_d = have_temp_q | temp_valid;
        set_reg_d   = grant ? sat(set_data) : set_reg_q;

        state_d = state_q;
        tcnt_d  = tcnt_q;
        blink_d = blink_q;
        unique case (state_q)
            SPLASH: begin
                if (tick) begin
                    if (tcnt_q == SPLASH_LAST) begin
                        state_d = have_temp_q ? TEMP : WAIT;
                        tcnt_d  = '0;
                        blink_d = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                end
            end
            WAIT: begin
                if (grant) begin
                    state_d = SET;
                    tcnt_d  = '0;
                end else if (have_temp_q) begin
                    state_d = TEMP;
                    tcnt_d  = '0;
                    blink_d = 1'b0;
                end
            end
            TEMP: begin
                if (grant) begin
                    state_d = SET;
                    tcnt_d  = '0;
                end else if (!alarm) begin
                    tcnt_d  = '0;
                    blink_d = 1'b0;
                end else if (tick) begin
                    if (tcnt_q == BLINK_LAST) begin
                        tcnt_d  = '0;
                        blink_d = ~blink_q;
                    end else begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                end
            end
            SET: begin
                // a re-grant on a tick cycle takes priority over hold expiry
                if (grant) begin
                    tcnt_d = '0;
                end else if (tick) begin
                    if (tcnt_q == HOLD_LAST) begin
                        state_d = have_temp_q ? TEMP : WAIT;
                        tcnt_d  = '0;
                        blink_d = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                end
            end
            default: state_d = SPLASH;
        endcase

        // blank hides the value but keeps disp_data stable for the driver
        mode_d = mode_q;
        data_d = data_q;
        unique case (state_q)
            SPLASH: begin
                mode_d = MODE_ID;
                data_d = '0;
            end
            WAIT: mode_d = MODE_BLANK;
            TEMP: begin
                if (blink_q && alarm) begin
                    mode_d = MODE_BLANK;
                end else begin
                    mode_d = MODE_NUM;
                    data_d = temp_reg_q;
                end
            end
            SET: begin
                mode_d = MODE_NUM;
                data_d = set_reg_q;
            end
            default: mode_d = MODE_ID;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            tcnt_q      <= '0;
            state_q     <= SPLASH;
            temp_reg_q  <= '0;
            set_reg_q   <= '0;
            have_temp_q <= 1'b0;
            blink_q     <= 1'b0;
            armed_q     <= 1'b1;
            mode_q      <= MODE_ID;
            data_q      <= '0;
        end else begin
            presc_q     <= presc_d;
            tcnt_q      <= tcnt_d;
            state_q     <= state_d;
            temp_reg_q  <= temp_reg_d;
            set_reg_q   <= set_reg_d;
            have_temp_q <= have_temp_d;
            blink_q     <= blink_d;
            armed_q     <= armed_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
        end
    end

    assign set_ack   = grant;
    assign disp_mode = mode_q;
    assign disp_data = data_q;
    assign state     = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with small timing parameters.
// The tick lands on every 4th edge after reset release, and the expected timings are counted from that edge.
module tb_display_scheduler;

    localparam logic [1:0] S_SPLASH = 2'b00;
    localparam logic [1:0] S_WAIT   = 2'b01;
    localparam logic [1:0] S_TEMP   = 2'b10;
    localparam logic [1:0] S_SET    = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        temp_valid = 1'b0;
    logic [15:0] temp_data = '0;
    logic        set_req = 1'b0;
    logic [15:0] set_data = '0;
    logic        alarm = 1'b0;
    logic        set_ack;
    logic [1:0]  disp_mode;
    logic [15:0] disp_data;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    display_scheduler #(
        .TICK_DIV(4),
        .SPLASH_TICKS(3),
        .HOLD_TICKS(5),
        .BLINK_TICKS(2),
        .MAX_VAL(9999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .temp_valid(temp_valid),
        .temp_data(temp_data),
        .set_req(set_req),
        .set_data(set_data),
        .set_ack(set_ack),
        .alarm(alarm),
        .disp_mode(disp_mode),
        .disp_data(disp_data),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic align4();
        while (cyc % 4 != 0) step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (state !== S_SPLASH) begin errors++; $display("FAIL rst_state got %0d exp %0d", state, S_SPLASH); end
        checks++; if (disp_mode !== 2'b00) begin errors++; $display("FAIL rst_mode got %0d exp 0", disp_mode); end
        checks++; if (disp_data !== 16'd0) begin errors++; $display("FAIL rst_data got %0d exp 0", disp_data); end
        checks++; if (set_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %0d exp 0", set_ack); end
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_splash();
        logic [1:0] em, es;
        for (int k = 1; k <= 13; k++) begin
            step();
            em = (k <= 12) ? 2'b00 : 2'b10;
            es = (k < 12) ? S_SPLASH : S_WAIT;
            checks++; if (disp_mode !== em) begin errors++; $display("FAIL splash_mode k=%0d got %0d exp %0d", k, disp_mode, em); end
            checks++; if (state !== es) begin errors++; $display("FAIL splash_state k=%0d got %0d exp %0d", k, state, es); end
        end
    endtask

    task automatic test_splash_req();
        logic [1:0] es;
        @(negedge clk);
        reset = 1'b0;
        set_req = 1'b1;
        set_data = 16'd4321;
        #1;
        checks++; if (set_ack !== 1'b0) begin errors++; $display("FAIL sreq_ack_rst got %0d exp 0", set_ack); end
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 11; k++) begin
            step();
            checks++; if (set_ack !== 1'b0) begin errors++; $display("FAIL sreq_ack_splash k=%0d got %0d exp 0", k, set_ack); end
        end
        step();
        checks++; if (state !== S_WAIT) begin errors++; $display("FAIL sreq_wait got %0d exp %0d", state, S_WAIT); end
        checks++; if (set_ack !== 1'b1) begin errors++; $display("FAIL sreq_ack_wait got %0d exp 1", set_ack); end
        step();
        checks++; if (set_ack !== 1'b0) begin errors++; $display("FAIL sreq_ack_pulse got %0d exp 0", set_ack); end
        checks++; if (state !== S_SET) begin errors++; $display("FAIL sreq_set got %0d exp %0d", state, S_SET); end
        set_req = 1'b0;
        step();
        checks++; if (disp_mode !== 2'b01 || disp_data !== 16'd4321) begin errors++; $display("FAIL sreq_disp got %0d/%0d exp 1/4321", disp_mode, disp_data); end
        while (cyc < 33) begin
            step();
            es = (cyc < 32) ? S_SET : S_WAIT;
            checks++; if (state !== es) begin errors++; $display("FAIL sreq_hold cyc=%0d got %0d exp %0d", cyc, state, es); end
        end
        checks++; if (disp_mode !== 2'b10 || disp_data !== 16'd4321) begin errors++; $display("FAIL sreq_blank got %0d/%0d exp 2/4321", disp_mode, disp_data); end
    endtask

    task automatic test_temp();
        logic [15:0] tin  [5] = '{16'd12000, 16'd9999, 16'd10000, 16'd0, 16'd253};
        logic [15:0] tout [5] = '{16'd9999, 16'd9999, 16'd9999, 16'd0, 16'd253};
        temp_valid = 1'b1;
        temp_data = 16'd253;
        step();
        temp_valid = 1'b0;
        step();
        checks++; if (state !== S_TEMP) begin errors++; $display("FAIL temp_state got %0d exp %0d", state, S_TEMP); end
        step();
        checks++; if (disp_mode !== 2'b01 || disp_data !== 16'd253) begin errors++; $display("FAIL temp_first got %0d/%0d exp 1/253", disp_mode, disp_data); end
        for (int i = 0; i < 5; i++) begin
            temp_valid = 1'b1;
            temp_data = tin[i];
            step();
            temp_valid = 1'b0;
            step();
            checks++; if (disp_data !== tout[i]) begin errors++; $display("FAIL temp_sat in=%0d got %0d exp %0d", tin[i], disp_data, tout[i]); end
        end
    endtask

    task automatic test_set();
        logic [1:0] es;
        align4();
        set_req = 1'b1;
        set_data = 16'd300;
        #1;
        checks++; if (set_ack !== 1'b1) begin errors++; $display("FAIL set_ack got %0d exp 1", set_ack); end
        step();
        checks++; if (set_ack !== 1'b0) begin errors++; $display("FAIL set_ack_pulse got %0d exp 0", set_ack); end
        set_req = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            step();
            es = (i < 19) ? S_SET : S_TEMP;
            checks++; if (disp_data !== 16'd300 || state !== es) begin errors++; $display("FAIL set_hold i=%0d got %0d/%0d exp 300/%0d", i, disp_data, state, es); end
        end
        step();
        checks++; if (disp_mode !== 2'b01 || disp_data !== 16'd253) begin errors++; $display("FAIL set_return got %0d/%0d exp 1/253", disp_mode, disp_data); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] es;
        align4();
        set_req = 1'b1;
        set_data = 16'd300;
        step();
        checks++; if (state !== S_SET || set_ack !== 1'b0) begin errors++; $display("FAIL b2b_grant got %0d/%0d exp 3/0", state, set_ack); end
        step();
        checks++; if (set_ack !== 1'b0) begin errors++; $display("FAIL b2b_nolow got %0d exp 0", set_ack); end
        set_req = 1'b0;
        repeat (17) step();
        checks++; if (state !== S_SET) begin errors++; $display("FAIL b2b_pre got %0d exp %0d", state, S_SET); end
        set_req = 1'b1;
        set_data = 16'd310;
        #1;
        checks++; if (set_ack !== 1'b1) begin errors++; $display("FAIL b2b_reack got %0d exp 1", set_ack); end
        step();
        checks++; if (state !== S_SET) begin errors++; $display("FAIL b2b_tick_win got %0d exp %0d", state, S_SET); end
        set_req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            es = (i < 20) ? S_SET : S_TEMP;
            checks++; if (disp_data !== 16'd310 || state !== es) begin errors++; $display("FAIL b2b_hold i=%0d got %0d/%0d exp 310/%0d", i, disp_data, state, es); end
        end
        step();
        checks++; if (disp_data !== 16'd253) begin errors++; $display("FAIL b2b_return got %0d exp 253", disp_data); end
    endtask

    task automatic test_alarm();
        logic [1:0] em;
        align4();
        alarm = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            step();
            em = ((i >= 9 && i <= 16) || i >= 25) ? 2'b10 : 2'b01;
            checks++; if (disp_mode !== em || disp_data !== 16'd253) begin errors++; $display("FAIL alarm_blink i=%0d got %0d/%0d exp %0d/253", i, disp_mode, disp_data, em); end
        end
        alarm = 1'b0;
        step();
        checks++; if (disp_mode !== 2'b01) begin errors++; $display("FAIL alarm_off got %0d exp 1", disp_mode); end
    endtask

    task automatic test_simultaneous();
        int n;
        set_req = 1'b1;
        set_data = 16'd500;
        temp_valid = 1'b1;
        temp_data = 16'd777;
        #1;
        checks++; if (set_ack !== 1'b1) begin errors++; $display("FAIL sim_ack got %0d exp 1", set_ack); end
        step();
        set_req = 1'b0;
        temp_valid = 1'b0;
        step();
        checks++; if (disp_mode !== 2'b01 || disp_data !== 16'd500) begin errors++; $display("FAIL sim_set got %0d/%0d exp 1/500", disp_mode, disp_data); end
        n = 0;
        while (state !== S_TEMP && n < 40) begin
            step();
            n++;
        end
        checks++; if (state !== S_TEMP) begin errors++; $display("FAIL sim_timeout got %0d exp %0d", state, S_TEMP); end
        step();
        checks++; if (disp_data !== 16'd777) begin errors++; $display("FAIL sim_bg_temp got %0d exp 777", disp_data); end
    endtask

    task automatic test_reset_mid_set();
        set_req = 1'b1;
        set_data = 16'd42;
        step();
        set_req = 1'b0;
        repeat (2) step();
        checks++; if (state !== S_SET) begin errors++; $display("FAIL mid_pre got %0d exp %0d", state, S_SET); end
        reset = 1'b0;
        #1;
        checks++; if (state !== S_SPLASH || disp_mode !== 2'b00 || disp_data !== 16'd0 || set_ack !== 1'b0) begin
            errors++; $display("FAIL mid_async got %0d/%0d/%0d/%0d exp 0/0/0/0", state, disp_mode, disp_data, set_ack);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        repeat (12) step();
        checks++; if (state !== S_WAIT || disp_mode !== 2'b00) begin errors++; $display("FAIL mid_splash got %0d/%0d exp 1/0", state, disp_mode); end
        step();
        checks++; if (disp_mode !== 2'b10 || disp_data !== 16'd0) begin errors++; $display("FAIL mid_wait got %0d/%0d exp 2/0", disp_mode, disp_data); end
    endtask

    initial begin
        test_reset();
        test_splash();
        test_splash_req();
        test_temp();
        test_set();
        test_back_to_back();
        test_alarm();
        test_simultaneous();
        test_reset_mid_set();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
